// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target controller: protocol state set,
// address width and the address-compare helper.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        WAIT_STOP
    } i2c_state_t;

    // The first byte after START carries the address in [7:1] and R/W in [0].
    function automatic logic addr_match(input logic [7:0]            i_byte,
                                        input logic [I2C_ADDR_W-1:0] i_addr);
        return (i_byte[7:1] == i_addr);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Oversamples one raw I2C pin: a 2-flop synchronizer plus one history flop.
// All flops reset to 1 so that an idle bus yields no edges out of reset.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronize the pin and keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign lvl  = r_s2;
    assign rise = r_s2 & ~r_s3;
    assign fall = ~r_s2 & r_s3;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target-side protocol controller for a fixed 7-bit address.
// Detects START/STOP on the synchronized lines, shifts address and data,
// drives ACKs and read data through an open-drain enable, and hands
// received bytes / read-data requests to the surrounding logic.
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       addr_hit,
    output logic       rw,
    output logic       busy
);

    logic       w_scl_lvl;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_sda_lvl;
    logic       w_sda_rise;
    logic       w_sda_fall;
    logic       w_scl_high;
    logic       w_start;
    logic       w_stop;
    logic       w_last_bit;
    logic [7:0] w_next_byte;

    i2c_state_t r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    // Marks the second half of an ACK slot: set once the first SCL event of
    // the slot has been handled (ACK driven, or master ACK seen in TX_ACK).
    logic       r_ack_half;
    logic       r_sda_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;
    logic       r_addr_hit;
    logic       r_rw;
    logic       r_busy;

    i2c_line_sync u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (scl_in),
        .lvl   (w_scl_lvl),
        .rise  (w_scl_rise),
        .fall  (w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (sda_in),
        .lvl   (w_sda_lvl),
        .rise  (w_sda_rise),
        .fall  (w_sda_fall)
    );

    // SCL has been high for two consecutive samples (s2 = s3 = 1).
    assign w_scl_high  = w_scl_lvl & ~w_scl_rise;
    assign w_start     = w_sda_fall & w_scl_high;
    assign w_stop      = w_sda_rise & w_scl_high;
    assign w_last_bit  = (r_bit_cnt == 3'd7);
    assign w_next_byte = {r_shift[6:0], w_sda_lvl};

    // Protocol sequencer; START/STOP override any bit activity this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ack_half <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_addr_hit <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_addr_hit <= 1'b0;

            if (w_stop) begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_ack_half <= 1'b0;
            end else if (w_start) begin
                r_state    <= ADDR;
                r_bit_cnt  <= '0;
                r_sda_oe   <= 1'b0;
                r_ack_half <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_sda_oe <= 1'b0;
                    end

                    ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_next_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if (addr_match(w_next_byte, SLAVE_ADDR)) begin
                                    r_addr_hit <= 1'b1;
                                    r_rw       <= w_next_byte[0];
                                    r_busy     <= 1'b1;
                                    r_state    <= ADDR_ACK;
                                end else begin
                                    r_busy  <= 1'b0;
                                    r_state <= WAIT_STOP;
                                end
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_half) begin
                                r_sda_oe   <= 1'b1;
                                r_ack_half <= 1'b1;
                                r_tx_req   <= r_rw;
                            end else begin
                                r_ack_half <= 1'b0;
                                if (r_rw) begin
                                    // Release ACK and present the read MSB in one step.
                                    r_shift  <= tx_data;
                                    r_sda_oe <= ~tx_data[7];
                                    r_state  <= TX;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= RX;
                                end
                            end
                        end
                    end

                    RX: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_next_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_rx_data  <= w_next_byte;
                                r_rx_valid <= 1'b1;
                                r_state    <= RX_ACK;
                            end
                        end
                    end

                    RX_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_half) begin
                                r_sda_oe   <= 1'b1;
                                r_ack_half <= 1'b1;
                            end else begin
                                r_sda_oe   <= 1'b0;
                                r_ack_half <= 1'b0;
                                r_state    <= RX;
                            end
                        end
                    end

                    TX: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= TX_ACK;
                            end else begin
                                r_sda_oe <= ~r_shift[6];
                                r_shift  <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end

                    TX_ACK: begin
                        if (w_scl_rise && !r_ack_half) begin
                            if (!w_sda_lvl) begin
                                r_tx_req   <= 1'b1;
                                r_ack_half <= 1'b1;
                            end else begin
                                r_state <= WAIT_STOP;
                            end
                        end else if (w_scl_fall && r_ack_half) begin
                            r_ack_half <= 1'b0;
                            r_shift    <= tx_data;
                            r_sda_oe   <= ~tx_data[7];
                            r_state    <= TX;
                        end
                    end

                    WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        r_state  <= IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign addr_hit = r_addr_hit;
    assign rw       = r_rw;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: a bus master drives SCL/SDA,
// a transaction-level model predicts events into a scoreboard queue and a
// monitor compares them against addr_hit / rx_valid / tx_req as they occur.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;

    localparam int Q = 60;           // quarter SCL period in ns (SCL = 24 clk)
    localparam logic [1:0] K_ADDR  = 2'd0;
    localparam logic [1:0] K_RX    = 2'd1;
    localparam logic [1:0] K_TXREQ = 2'd2;
    localparam logic [6:0] TGT     = 7'h50;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       w_sda;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       addr_hit;
    logic       rw;
    logic       busy;

    evt_t       exp_q[$];
    logic [7:0] tx_src[$];
    logic [7:0] xb[$];
    int         errors = 0;
    int         checks = 0;
    logic       oe_seen = 1'b0;

    // Open-drain bus: either side can pull low.
    assign w_sda = sda_m & ~sda_oe;

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl),
        .sda_in   (w_sda),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .addr_hit (addr_hit),
        .rw       (rw),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void got(input logic [1:0] k, input logic [7:0] d);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind %0d data %02h expected none", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.data !== d) begin
                errors++;
                $display("FAIL event: got kind %0d data %02h expected kind %0d data %02h",
                         k, d, e.kind, e.data);
            end
        end
    endfunction

    // Monitor: compare DUT output pulses against the scoreboard, serve read data.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sda_oe) oe_seen = 1'b1;
                if (addr_hit) got(K_ADDR, {7'b0, rw});
                if (rx_valid) got(K_RX, rx_data);
                if (tx_req) begin
                    got(K_TXREQ, 8'h00);
                    if (tx_src.size() > 0) tx_data = tx_src.pop_front();
                end
            end
        end
    end

    task automatic start_cond();
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic wr_bit(input logic b);
        sda_m = b; #Q;
        scl   = 1'b1; #(2*Q);
        scl   = 1'b0; #Q;
    endtask

    task automatic rd_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        b     = w_sda; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input string nm);
        logic a;
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(a);
        chk(nm, {31'b0, a}, exp_ack ? 32'd0 : 32'd1);
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic ack);
        logic [7:0] v;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            v[i] = b;
        end
        chk("rd_data", {24'b0, v}, {24'b0, exp});
        wr_bit(~ack);
    endtask

    // Transaction model: predict events from address/R-W and the byte list in xb.
    task automatic do_xfer(input logic [7:0] abyte);
        logic match;
        logic rd;
        match = (abyte[7:1] == TGT);
        rd    = abyte[0];
        oe_seen = 1'b0;
        if (match) begin
            exp_q.push_back('{kind: K_ADDR, data: {7'b0, rd}});
            if (rd) begin
                foreach (xb[i]) begin
                    exp_q.push_back('{kind: K_TXREQ, data: 8'h00});
                    tx_src.push_back(xb[i]);
                end
            end else begin
                foreach (xb[i]) exp_q.push_back('{kind: K_RX, data: xb[i]});
            end
        end
        start_cond();
        wr_byte(abyte, match, "addr_ack");
        chk("busy_addr", {31'b0, busy}, {31'b0, match});
        if (!match) begin
            foreach (xb[i]) wr_byte(xb[i], 1'b0, "nomatch_ack");
            chk("oe_nomatch", {31'b0, oe_seen}, 32'd0);
        end else if (!rd) begin
            foreach (xb[i]) wr_byte(xb[i], 1'b1, "data_ack");
        end else begin
            for (int i = 0; i < xb.size(); i++) rd_byte(xb[i], i != xb.size() - 1);
            chk("oe_after_nack", {31'b0, sda_oe}, 32'd0);
        end
        stop_cond();
        #Q;
        chk("busy_stop", {31'b0, busy}, 32'd0);
        chk("evq_drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [6:0] ra;
        logic [7:0] ab;
        int         n;

        #12;
        chk("reset_state", {18'b0, sda_oe, rx_data, rx_valid, tx_req, addr_hit, rw, busy}, 32'd0);
        #11 rst_n = 1'b1;
        @(negedge clk);
        #2;

        xb = {8'h3C};
        do_xfer(8'hA0);
        chk("rx_data_hold", {24'b0, rx_data}, 32'h3C);

        xb = {8'h96, 8'h5A};
        do_xfer(8'hA1);

        xb = {8'h5A, 8'h00};
        do_xfer(8'hA2);

        // Repeated START after 3 data bits: partial byte must be dropped.
        exp_q.push_back('{kind: K_ADDR, data: 8'h00});
        exp_q.push_back('{kind: K_ADDR, data: 8'h01});
        exp_q.push_back('{kind: K_TXREQ, data: 8'h00});
        tx_src.push_back(8'hC3);
        start_cond();
        wr_byte(8'hA0, 1'b1, "rs_addr_ack");
        wr_bit(1'b1);
        wr_bit(1'b0);
        wr_bit(1'b1);
        start_cond();
        wr_byte(8'hA1, 1'b1, "rs_addr2_ack");
        rd_byte(8'hC3, 1'b0);
        stop_cond();
        #Q;
        chk("rs_evq_drain", exp_q.size(), 32'd0);

        // Reset while the address ACK is on the bus.
        exp_q.push_back('{kind: K_ADDR, data: 8'h00});
        start_cond();
        for (int i = 7; i >= 0; i--) wr_bit(ab_bit(8'hA0, i));
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #(Q/2);
        chk("ack_before_rst", {31'b0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_oe", {31'b0, sda_oe}, 32'd0);
        chk("rst_outputs", {18'b0, sda_oe, rx_data, rx_valid, tx_req, addr_hit, rw, busy}, 32'd0);
        #20 rst_n = 1'b1;
        #Q;
        scl = 1'b0;
        #Q;
        chk("rst_evq", exp_q.size(), 32'd0);
        xb = {8'h11, 8'hEE};
        do_xfer(8'hA0);

        // Randomized transactions against the model.
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 3) != 0) begin
                ra = TGT;
            end else begin
                ra = 7'($urandom_range(0, 127));
                if (ra == TGT) ra = 7'h51;
            end
            ab = {ra, 1'($urandom_range(0, 1))};
            n  = $urandom_range(1, 3);
            xb = {};
            for (int i = 0; i < n; i++) xb.push_back(8'($urandom_range(0, 255)));
            do_xfer(ab);
        end

        #200;
        chk("evq_final", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic ab_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
